// File: rtl/ex_mem_skid_reg.sv
// ex_mem_skid_reg: EX->MEM pipeline register with two-entry skid buffer; stall counter under EX_MEM_STALL_CNT_EN
module ex_mem_skid_reg #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int MEMOP_W = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [REG_AW-1:0]  in_wd_i,
  input  logic               in_wreg_i,
  input  logic [DATA_W-1:0]  in_wdata_i,
  input  logic [MEMOP_W-1:0] in_memop_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [REG_AW-1:0]  out_wd_o,
  output logic               out_wreg_o,
  output logic [DATA_W-1:0]  out_wdata_o,
  output logic [MEMOP_W-1:0] out_memop_o
`ifdef EX_MEM_STALL_CNT_EN
  ,
  output logic [15:0]        stall_cnt_o
`endif
);
  logic mv, sv, rdy;
  logic [REG_AW-1:0] s_wd;
  logic s_wreg;
  logic [DATA_W-1:0] s_wdata;
  logic [MEMOP_W-1:0] s_memop;
  logic accept, take, load_m, load_s, pop_s, drain;
  assign accept = in_valid_i & rdy;
  assign take = mv & out_ready_i;
  assign load_m = accept & (~mv | take);
  assign load_s = accept & mv & ~take;
  assign pop_s = sv & take;
  assign drain = take & ~accept & ~sv;
  assign in_ready_o = rdy;
  assign out_valid_o = mv;
  // head/skid state; ready is its own flop so it never depends on out_ready_i combinationally
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mv <= 1'b0;
      sv <= 1'b0;
      rdy <= 1'b1;
      out_wd_o <= '0;
      out_wreg_o <= 1'b0;
      out_wdata_o <= '0;
      out_memop_o <= '0;
      s_wd <= '0;
      s_wreg <= 1'b0;
      s_wdata <= '0;
      s_memop <= '0;
    end else if (flush_i) begin
      mv <= 1'b0;
      sv <= 1'b0;
      rdy <= 1'b1;
      out_wreg_o <= 1'b0;
      out_memop_o <= '0;
      s_wreg <= 1'b0;
      s_memop <= '0;
    end else begin
      mv <= mv ? ~drain : accept;
      sv <= sv ? ~take : load_s;
      rdy <= sv ? take : ~load_s;
      if (load_m) begin
        out_wd_o <= in_wd_i;
        out_wreg_o <= in_wreg_i;
        out_wdata_o <= in_wdata_i;
        out_memop_o <= in_memop_i;
      end else if (pop_s) begin
        out_wd_o <= s_wd;
        out_wreg_o <= s_wreg;
        out_wdata_o <= s_wdata;
        out_memop_o <= s_memop;
      end else if (drain) begin
        out_wreg_o <= 1'b0;
        out_memop_o <= '0;
      end
      if (load_s) begin
        s_wd <= in_wd_i;
        s_wreg <= in_wreg_i;
        s_wdata <= in_wdata_i;
        s_memop <= in_memop_i;
      end
    end
  end
`ifdef EX_MEM_STALL_CNT_EN
  // saturating count of cycles a valid head waits on the memory stage; only reset clears it
  always_ff @(posedge clk_i) begin
    if (rst_i) stall_cnt_o <= '0;
    else if (mv & ~out_ready_i & ~&stall_cnt_o) stall_cnt_o <= stall_cnt_o + 16'd1;
  end
`endif
endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// tb_ex_mem_skid_reg: scoreboard bench for ex_mem_skid_reg
module tb_ex_mem_skid_reg;
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic flush_i = 1'b0;
  logic in_valid_i = 1'b0;
  logic in_ready_o;
  logic [4:0] in_wd_i = '0;
  logic in_wreg_i = 1'b0;
  logic [31:0] in_wdata_i = '0;
  logic [3:0] in_memop_i = '0;
  logic out_valid_o;
  logic out_ready_i = 1'b0;
  logic [4:0] out_wd_o;
  logic out_wreg_o;
  logic [31:0] out_wdata_o;
  logic [3:0] out_memop_o;
`ifdef EX_MEM_STALL_CNT_EN
  logic [15:0] stall_cnt_o;
`endif
  int checks = 0;
  int fails = 0;
  logic [41:0] q[$];
  ex_mem_skid_reg dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .flush_i(flush_i),
    .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o),
    .in_wd_i(in_wd_i),
    .in_wreg_i(in_wreg_i),
    .in_wdata_i(in_wdata_i),
    .in_memop_i(in_memop_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_wd_o(out_wd_o),
    .out_wreg_o(out_wreg_o),
    .out_wdata_o(out_wdata_o),
    .out_memop_o(out_memop_o)
`ifdef EX_MEM_STALL_CNT_EN
    ,
    .stall_cnt_o(stall_cnt_o)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", n, a, e);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [4:0] wd, input logic [31:0] d, input logic [3:0] m, input logic w, input bit exp);
    in_valid_i = 1'b1;
    in_wd_i = wd;
    in_wdata_i = d;
    in_memop_i = m;
    in_wreg_i = w;
    if (exp) q.push_back({wd, w, d, m});
  endtask
  // monitor: every take seen before the edge must match the oldest expected entry
  always @(negedge clk) begin
    if (!rst_i && out_valid_o && out_ready_i) begin
      if (q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_out got=%0h exp=none", {out_wd_o, out_wreg_o, out_wdata_o, out_memop_o});
      end else chk("take", {out_wd_o, out_wreg_o, out_wdata_o, out_memop_o}, q.pop_front());
    end
  end
  initial begin
    repeat (2) cyc;
    rst_i = 1'b0;
    chk("rst_valid", out_valid_o, 0);
    chk("rst_ready", in_ready_o, 1);
    chk("rst_data", {out_wd_o, out_wreg_o, out_wdata_o, out_memop_o}, 0);
`ifdef EX_MEM_STALL_CNT_EN
    chk("rst_cnt", stall_cnt_o, 0);
`endif
    out_ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      send(5'(i), 32'(i) * 32'h11, 4'(i), 1'b1, 1);
      cyc;
      chk("lat_valid", out_valid_o, 1);
      chk("lat_wd", out_wd_o, i);
    end
    in_valid_i = 1'b0;
    cyc;
    chk("drain_valid", out_valid_o, 0);
    chk("drain_wreg", out_wreg_o, 0);
    chk("drain_memop", out_memop_o, 0);
    chk("drain_wd_hold", out_wd_o, 4);
    chk("drain_wdata_hold", out_wdata_o, 32'h44);
    out_ready_i = 1'b0;
    send(5'd5, 32'hA5, 4'h2, 1'b1, 1);
    cyc;
    send(5'd6, 32'hA6, 4'h3, 1'b1, 1);
    cyc;
    in_valid_i = 1'b0;
    chk("skid_rdy", in_ready_o, 0);
    chk("skid_head", out_wd_o, 5);
    cyc;
    chk("skid_rdy_hold", in_ready_o, 0);
    chk("skid_head_hold", out_wd_o, 5);
    out_ready_i = 1'b1;
    cyc;
    chk("rdy_after_take", in_ready_o, 1);
    chk("head6", out_wd_o, 6);
    cyc;
    chk("skid_empty", out_valid_o, 0);
    out_ready_i = 1'b0;
    send(5'd7, 32'h77, 4'h5, 1'b1, 0);
    cyc;
    send(5'd8, 32'h88, 4'h6, 1'b1, 0);
    cyc;
    chk("skid2_rdy", in_ready_o, 0);
    flush_i = 1'b1;
    send(5'd9, 32'h99, 4'h7, 1'b1, 0);
    cyc;
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    chk("flush_valid", out_valid_o, 0);
    chk("flush_wreg", out_wreg_o, 0);
    chk("flush_memop", out_memop_o, 0);
    chk("flush_rdy", in_ready_o, 1);
    out_ready_i = 1'b1;
    repeat (3) cyc;
    chk("flush_gone", out_valid_o, 0);
    out_ready_i = 1'b0;
    send(5'd10, 32'hAA, 4'h8, 1'b1, 0);
    cyc;
    send(5'd11, 32'hBB, 4'h9, 1'b1, 0);
    cyc;
    in_valid_i = 1'b0;
    rst_i = 1'b1;
    out_ready_i = 1'b1;
    cyc;
    rst_i = 1'b0;
    chk("rst2_valid", out_valid_o, 0);
    chk("rst2_data", {out_wd_o, out_wreg_o, out_wdata_o, out_memop_o}, 0);
    chk("rst2_rdy", in_ready_o, 1);
    repeat (2) cyc;
    chk("rst2_gone", out_valid_o, 0);
    for (int i = 0; i < 8; i++) begin
      send(5'($urandom), $urandom, 4'($urandom), 1'($urandom), 1);
      cyc;
      chk("b2b_rdy", in_ready_o, 1);
    end
    in_valid_i = 1'b0;
    repeat (2) cyc;
`ifdef EX_MEM_STALL_CNT_EN
    chk("cnt_zero", stall_cnt_o, 0);
    out_ready_i = 1'b0;
    send(5'd12, 32'hC, 4'h1, 1'b1, 0);
    cyc;
    in_valid_i = 1'b0;
    repeat (10) cyc;
    chk("cnt10", stall_cnt_o, 10);
    repeat (65530) cyc;
    chk("cnt_sat", stall_cnt_o, 16'hFFFF);
    flush_i = 1'b1;
    cyc;
    flush_i = 1'b0;
    cyc;
    chk("cnt_flush", stall_cnt_o, 16'hFFFF);
    chk("cnt_flush_valid", out_valid_o, 0);
    out_ready_i = 1'b1;
`endif
    cyc;
    chk("q_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
